// File: rtl/esm_core_mi.sv
// esm_core_mi: circular instruction window with in-window RAW (optional WAW) checks,
// multi-issue oldest-first select, completion ports and in-order retire.
// Ports:
//   clk, rst (async, active-high).
//   Instr_in, in_valid, ALUSrc, RegWrite, in_ready: enqueue side.
//   issue_valid, issue_index, issue_instr: issue slots.
//   cmp_valid, cmp_index: completion ports.
//   occupancy: number of valid entries.
// Build option: ESM_WAW_CHECK_EN also blocks a writer behind an older pending writer of the same rd.
module esm_core_mi #(
  parameter int Instr_word_size = 32,
  parameter int regnum = 32,
  parameter int bs = 16,
  parameter int issue_width = 2,
  localparam int bs_bits = $clog2(bs)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [Instr_word_size-1:0]         Instr_in,
  input  logic                               in_valid,
  input  logic                               ALUSrc,
  input  logic                               RegWrite,
  output logic                               in_ready,
  output logic [issue_width-1:0]             issue_valid,
  output logic [issue_width*bs_bits-1:0]     issue_index,
  output logic [issue_width*Instr_word_size-1:0] issue_instr,
  input  logic [issue_width-1:0]             cmp_valid,
  input  logic [issue_width*bs_bits-1:0]     cmp_index,
  output logic [bs_bits:0]                   occupancy
);

  localparam int W  = Instr_word_size;
  localparam int BB = bs_bits;
  localparam logic [BB:0] FULL = (BB+1)'(bs);

  typedef logic [BB-1:0] idx_t;

  logic [bs-1:0] valid_q, valid_d;
  logic [bs-1:0] issued_q, issued_d;
  logic [bs-1:0] done_q, done_d;
  logic [bs-1:0] alusrc_q, alusrc_d;
  logic [bs-1:0] regwr_q, regwr_d;
  logic [W-1:0]  instr_q [bs];
  logic [W-1:0]  instr_d [bs];
  idx_t          head_q, head_d;
  idx_t          tail_q, tail_d;
  logic [BB:0]   count_q, count_d;

  logic [bs-1:0] rdy;
  logic [bs-1:0] sel;

  // x0 and registers outside the architectural file never carry a dependency.
  function automatic logic live_reg(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < regnum);
  endfunction

  assign in_ready  = (count_q != FULL);
  assign occupancy = count_q;

  // Ready per physical slot; age is the offset from head, so only
  // smaller offsets can block.
  always_comb begin
    idx_t ei;
    idx_t oi;
    logic blk;
    logic [4:0] ord;
    rdy = '0;
    for (int i = 0; i < bs; i++) begin
      ei  = head_q + BB'(i);
      blk = 1'b0;
      for (int j = 0; j < i; j++) begin
        oi  = head_q + BB'(j);
        ord = instr_q[oi][11:7];
        if (valid_q[oi] && !done_q[oi] &&
            regwr_q[oi] && live_reg(ord)) begin
          if (ord == instr_q[ei][19:15])
            blk = 1'b1;
          if (!alusrc_q[ei] &&
              ord == instr_q[ei][24:20])
            blk = 1'b1;
`ifdef ESM_WAW_CHECK_EN
          if (regwr_q[ei] &&
              ord == instr_q[ei][11:7])
            blk = 1'b1;
`endif
        end
      end
      rdy[ei] = valid_q[ei] && !issued_q[ei] && !blk;
    end
  end

  // Slot s takes the s-th oldest ready entry.
  always_comb begin
    idx_t ei;
    logic found;
    issue_valid = '0;
    issue_index = '0;
    issue_instr = '0;
    sel         = '0;
    for (int s = 0; s < issue_width; s++) begin
      found = 1'b0;
      for (int i = 0; i < bs; i++) begin
        ei = head_q + BB'(i);
        if (!found && rdy[ei] && !sel[ei]) begin
          found                      = 1'b1;
          sel[ei]                    = 1'b1;
          issue_valid[s]             = 1'b1;
          issue_index[s*BB +: BB]    = ei;
          issue_instr[s*W +: W]      = instr_q[ei];
        end
      end
    end
  end

  always_comb begin
    idx_t ci;
    idx_t ri;
    logic stop;
    logic enq;
    logic [BB:0] ret;
    valid_d  = valid_q;
    issued_d = issued_q | sel;
    done_d   = done_q;
    alusrc_d = alusrc_q;
    regwr_d  = regwr_q;
    instr_d  = instr_q;
    tail_d   = tail_q;
    ret      = '0;
    stop     = 1'b0;
    enq      = in_valid && in_ready;
    for (int p = 0; p < issue_width; p++) begin
      ci = cmp_index[p*BB +: BB];
      if (cmp_valid[p] && valid_q[ci] && issued_q[ci])
        done_d[ci] = 1'b1;
    end
    // Same-edge completions count as done, so a finishing head retires at once.
    for (int k = 0; k < issue_width; k++) begin
      ri = head_q + BB'(k);
      if (!stop && valid_q[ri] && done_d[ri]) begin
        valid_d[ri] = 1'b0;
        ret         = ret + (BB+1)'(1);
      end else begin
        stop = 1'b1;
      end
    end
    // Tail slot is never valid here since in_ready uses the registered count.
    if (enq) begin
      valid_d[tail_q]  = 1'b1;
      issued_d[tail_q] = 1'b0;
      done_d[tail_q]   = 1'b0;
      alusrc_d[tail_q] = ALUSrc;
      regwr_d[tail_q]  = RegWrite;
      instr_d[tail_q]  = Instr_in;
      tail_d           = tail_q + idx_t'(1);
    end
    head_d  = head_q + ret[BB-1:0];
    count_d = count_q + (BB+1)'(enq) - ret;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
      alusrc_q <= '0;
      regwr_q  <= '0;
      for (int i = 0; i < bs; i++)
        instr_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      alusrc_q <= alusrc_d;
      regwr_q  <= regwr_d;
      instr_q  <= instr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_esm_core_mi.sv
// tb_esm_core_mi: directed vector table plus hand sequences
// for reset, full window, wrap and age order.
module tb_esm_core_mi;
  localparam int W  = 32;
  localparam int BS = 16;
  localparam int IW = 2;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  instr_in;
  logic          in_valid;
  logic          alu_src;
  logic          reg_write;
  logic          in_ready;
  logic [IW-1:0] issue_valid;
  logic [IW*BB-1:0] issue_index;
  logic [IW*W-1:0]  issue_instr;
  logic [IW-1:0] cmp_valid;
  logic [IW*BB-1:0] cmp_index;
  logic [BB:0]   occupancy;

  esm_core_mi #(
    .Instr_word_size(W),
    .regnum(32),
    .bs(BS),
    .issue_width(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Instr_in(instr_in),
    .in_valid(in_valid),
    .ALUSrc(alu_src),
    .RegWrite(reg_write),
    .in_ready(in_ready),
    .issue_valid(issue_valid),
    .issue_index(issue_index),
    .issue_instr(issue_instr),
    .cmp_valid(cmp_valid),
    .cmp_index(cmp_index),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        inv;
    logic [31:0] ins;
    logic        alu;
    logic        rw;
    logic [1:0]  cv;
    logic [3:0]  c0;
    logic [3:0]  c1;
    logic        e_rdy;
    logic [1:0]  e_iv;
    logic [3:0]  e_x0;
    logic [3:0]  e_x1;
    logic [4:0]  e_occ;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] r_add(int rd, int rs1, int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] r_sub(int rd, int rs1, int rs2);
    return {7'h20, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic put(input int inv, input logic [31:0] ins, input int alu, input int rw,
                     input int cv, input int c0, input int c1,
                     input int e_rdy, input int e_iv, input int e_x0, input int e_x1, input int e_occ);
    vec_t v;
    v.inv = 1'(inv); v.ins = ins; v.alu = 1'(alu); v.rw = 1'(rw);
    v.cv = 2'(cv); v.c0 = 4'(c0); v.c1 = 4'(c1);
    v.e_rdy = 1'(e_rdy); v.e_iv = 2'(e_iv);
    v.e_x0 = 4'(e_x0); v.e_x1 = 4'(e_x1); v.e_occ = 5'(e_occ);
    tv.push_back(v);
  endtask

  // Drive at the current negedge, clock once, return at the next negedge.
  task automatic cyc(input int inv, input logic [31:0] ins, input int alu, input int rw,
                     input int cv, input int c0, input int c1);
    in_valid  = 1'(inv);
    instr_in  = ins;
    alu_src   = 1'(alu);
    reg_write = 1'(rw);
    cmp_valid = 2'(cv);
    cmp_index = {4'(c1), 4'(c0)};
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    cmp_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    instr_in = '0; in_valid = 1'b0; alu_src = 1'b0; reg_write = 1'b0;
    cmp_valid = '0; cmp_index = '0;

    // Dual issue after a shared producer completes.
    put(1, r_add(2,5,6), 0,1, 0,0,0, 1,1,0,0,1);
    put(1, r_add(1,2,3), 0,1, 0,0,0, 1,0,0,0,2);
    put(1, r_add(4,2,6), 0,1, 0,0,0, 1,0,0,0,3);
    put(0, 0, 0,0, 1,0,0, 1,3,1,2,2);
    put(0, 0, 0,0, 0,0,0, 1,0,0,0,2);
    put(0, 0, 0,0, 3,2,1, 1,0,0,0,0);
    // RAW chain.
    put(1, r_add(1,2,3), 0,1, 0,0,0, 1,1,3,0,1);
    put(1, r_add(7,1,4), 0,1, 0,0,0, 1,0,0,0,2);
    put(0, 0, 0,0, 0,0,0, 1,0,0,0,2);
    put(0, 0, 0,0, 1,3,0, 1,1,4,0,1);
    put(0, 0, 0,0, 0,0,0, 1,0,0,0,1);
    // ALUSrc masking of the rs2 field.
    put(1, r_add(2,5,6), 0,1, 0,0,0, 1,1,5,0,2);
    put(1, {12'd2, 5'd1, 3'b000, 5'd9, 7'h13}, 1,1, 0,0,0, 1,1,6,0,3);
    put(1, r_add(10,1,2), 0,1, 0,0,0, 1,0,0,0,4);
    put(0, 0, 0,0, 1,5,0, 1,1,7,0,4);
    put(0, 0, 0,0, 3,4,6, 1,0,0,0,2);
    put(0, 0, 0,0, 0,0,0, 1,0,0,0,1);
    put(0, 0, 0,0, 2,0,7, 1,0,0,0,0);
    // Same rd, no RAW.
    put(1, r_add(5,2,3), 0,1, 0,0,0, 1,1,8,0,1);
`ifdef ESM_WAW_CHECK_EN
    put(1, r_sub(5,6,7), 0,1, 0,0,0, 1,0,0,0,2);
    put(0, 0, 0,0, 1,8,0, 1,1,9,0,1);
`else
    put(1, r_sub(5,6,7), 0,1, 0,0,0, 1,1,9,0,2);
    put(0, 0, 0,0, 1,8,0, 1,0,0,0,1);
`endif
    put(0, 0, 0,0, 0,0,0, 1,0,0,0,1);
    put(0, 0, 0,0, 1,9,0, 1,0,0,0,0);
    // Completions on invalid / not-yet-issued entries are ignored.
    put(0, 0, 0,0, 1,5,0, 1,0,0,0,0);
    put(1, r_add(3,5,6), 0,1, 0,0,0, 1,1,10,0,1);
    put(1, r_add(8,3,0), 0,1, 1,11,0, 1,0,0,0,2);
    put(0, 0, 0,0, 1,11,0, 1,0,0,0,2);
    put(0, 0, 0,0, 1,10,0, 1,1,11,0,1);
    put(0, 0, 0,0, 0,0,0, 1,0,0,0,1);
    put(0, 0, 0,0, 1,11,0, 1,0,0,0,0);

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_iv", 32'(issue_valid), 0);
    check("rst_ix", 32'(issue_index), 0);
    check("rst_instr", issue_instr[31:0], 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].inv, tv[i].ins, tv[i].alu, tv[i].rw, tv[i].cv, tv[i].c0, tv[i].c1);
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
      check($sformatf("v%0d_iv", i), 32'(issue_valid), 32'(tv[i].e_iv));
      check($sformatf("v%0d_ix0", i), 32'(issue_index[3:0]), 32'(tv[i].e_x0));
      check($sformatf("v%0d_ix1", i), 32'(issue_index[7:4]), 32'(tv[i].e_x1));
      check($sformatf("v%0d_occ", i), 32'(occupancy), 32'(tv[i].e_occ));
    end

    // Asynchronous reset in mid-cycle with an entry pending.
    in_valid = 1'b1; instr_in = r_add(1,0,0); reg_write = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(in_ready), 1);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_iv", 32'(issue_valid), 0);
    check("arst_ix", 32'(issue_index), 0);
    check("arst_instr", issue_instr[31:0], 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0,0, 1,3,0);
    check("post_rst_cmp_occ", 32'(occupancy), 0);
    check("post_rst_cmp_iv", 32'(issue_valid), 0);

    // Fill the window; only slot 15 writes (x11).
    for (int i = 0; i < BS; i++) begin
      if (i == BS-1) cyc(1, r_add(11,0,0), 0,1, 0,0,0);
      else           cyc(1, r_add(i+1,0,0) | 32'(i << 25), 0,0, 0,0,0);
    end
    check("full_occ", 32'(occupancy), 16);
    check("full_ready", 32'(in_ready), 0);
    check("full_iv", 32'(issue_valid), 1);
    check("full_ix0", 32'(issue_index[3:0]), 15);
    cyc(1, 32'hdead_beef, 0,1, 0,0,0);
    check("full_drop_occ", 32'(occupancy), 16);
    check("full_drop_iv", 32'(issue_valid), 0);
    cyc(0, 0, 0,0, 3,0,1);
    check("ret2_occ", 32'(occupancy), 14);
    check("ret2_ready", 32'(in_ready), 1);
    // P (idx0) reads x11 from slot 15, which is older across the wrap.
    cyc(1, r_add(4,11,0), 0,1, 0,0,0);
    check("wrap_p_occ", 32'(occupancy), 15);
    check("wrap_p_iv", 32'(issue_valid), 0);
    cyc(1, r_add(6,4,0), 0,1, 0,0,0);
    check("wrap_q_occ", 32'(occupancy), 16);
    check("wrap_q_ready", 32'(in_ready), 0);
    check("wrap_q_iv", 32'(issue_valid), 0);
    // Full: enqueue attempt plus retire of slot 2 on the same edge.
    cyc(1, 32'h1234_5678, 0,1, 3,15,2);
    check("fullret_occ", 32'(occupancy), 15);
    check("fullret_ready", 32'(in_ready), 1);
    check("wrap_p_issue", 32'(issue_valid), 1);
    check("wrap_p_ix", 32'(issue_index[3:0]), 0);
    check("wrap_p_instr", issue_instr[31:0], r_add(4,11,0));
    cyc(0, 0, 0,0, 0,0,0);
    check("wrap_q_blocked", 32'(issue_valid), 0);
    cyc(0, 0, 0,0, 1,0,0);
    check("wrap_q_issue", 32'(issue_valid), 1);
    check("wrap_q_ix", 32'(issue_index[3:0]), 1);
    check("wrap_q_instr", issue_instr[31:0], r_add(6,4,0));
    check("wrap_occ", 32'(occupancy), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
